// File: rtl/gf2e_pkg.sv
// Shared GF(2^16) lane geometry, field constants and control enums for the
// Goppa-polynomial evaluator back end.
package gf2e_pkg;

    localparam int W     = 16;
    localparam int LANES = 9;
    localparam int m     = LANES * W;

    // x^16 + x^12 + x^3 + x + 1; must be the same field the external MUL_ARRAY uses
    localparam logic [W:0]   GF_POLY = 17'h1100B;
    localparam logic [W-1:0] INV_EXP = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_e;

    typedef enum logic {
        SQR,
        MUL
    } op_e;

    typedef logic [LANES-1:0][W-1:0] lane_vec_t;

    // Reference single-lane product in the same field as MUL_ARRAY.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] p;
        logic [W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) p = p ^ x;
            x = x[W-1] ? ((x << 1) ^ GF_POLY[W-1:0]) : (x << 1);
        end
        return p;
    endfunction

endpackage

// File: rtl/gopf_inv_seq.sv
// Exponent walker for the Fermat inversion: steps MSB-first through INV_EXP,
// selecting SQR or MUL for each multiplier pass and flagging the final op.
module gopf_inv_seq
    import gf2e_pkg::*;
(
    input  logic clk,
    input  logic rst_b,
    input  logic load,
    input  logic advance,
    output op_e  op,
    output logic last_op
);

    // Bit W-1 of the exponent is absorbed by starting the accumulator at a.
    localparam logic [3:0] START_BIT = 4'(W - 2);

    logic [3:0] bit_idx;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            bit_idx <= '0;
            op      <= SQR;
        end else if (load) begin
            bit_idx <= START_BIT;
            op      <= SQR;
        end else if (advance && !last_op) begin
            if (op == SQR && INV_EXP[bit_idx] && bit_idx != 4'd0) begin
                op <= MUL;
            end else begin
                op      <= SQR;
                bit_idx <= bit_idx - 4'd1;
            end
        end
    end

    assign last_op = (op == SQR) && (bit_idx == 4'd0);

endmodule

// File: rtl/gopf_inv_batch.sv
// Nine-lane GF(2^16) batch inverter (a^(2^16-2)) time-shared on the external
// MUL_ARRAY. Optional zero_flag output is enabled by GOPF_INV_ZERO_FLAG_EN.
module gopf_inv_batch
    import gf2e_pkg::*;
(
    input  logic           clk,
    input  logic           rst_b,
    input  logic           start,
    input  logic [0:m-1]   eval_dat,
    output logic [0:m-1]   inv_r_dat,
    output logic           inv_done,
    output logic           busy,
`ifdef GOPF_INV_ZERO_FLAG_EN
    output logic [0:LANES-1] zero_flag,
`endif
    output logic [0:W-1]   mul1_o_out,
    output logic [0:W-1]   mul2_o_out,
    output logic [0:W-1]   mul3_o_out,
    output logic [0:W-1]   mul4_o_out,
    output logic [0:W-1]   mul5_o_out,
    output logic [0:W-1]   mul6_o_out,
    output logic [0:W-1]   mul7_o_out,
    output logic [0:W-1]   mul8_o_out,
    output logic [0:W-1]   mul9_o_out,
    output logic [0:W-1]   mul1_t_out,
    output logic [0:W-1]   mul2_t_out,
    output logic [0:W-1]   mul3_t_out,
    output logic [0:W-1]   mul4_t_out,
    output logic [0:W-1]   mul5_t_out,
    output logic [0:W-1]   mul6_t_out,
    output logic [0:W-1]   mul7_t_out,
    output logic [0:W-1]   mul8_t_out,
    output logic [0:W-1]   mul9_t_out,
    output logic [0:W-1]   mul1_add_out,
    output logic [0:W-1]   mul2_add_out,
    output logic [0:W-1]   mul3_add_out,
    output logic [0:W-1]   mul4_add_out,
    output logic [0:W-1]   mul5_add_out,
    output logic [0:W-1]   mul6_add_out,
    output logic [0:W-1]   mul7_add_out,
    output logic [0:W-1]   mul8_add_out,
    output logic [0:W-1]   mul9_add_out,
    input  logic [0:W-1]   mul1_r_dat,
    input  logic [0:W-1]   mul2_r_dat,
    input  logic [0:W-1]   mul3_r_dat,
    input  logic [0:W-1]   mul4_r_dat,
    input  logic [0:W-1]   mul5_r_dat,
    input  logic [0:W-1]   mul6_r_dat,
    input  logic [0:W-1]   mul7_r_dat,
    input  logic [0:W-1]   mul8_r_dat,
    input  logic [0:W-1]   mul9_r_dat
);

    state_e    state_q, state_d;
    op_e       op;
    logic      last_op;
    logic      accept;
    logic      advance;

    lane_vec_t eval_vec;
    lane_vec_t a_q;
    lane_vec_t r_q;
    lane_vec_t o_q;
    lane_vec_t t_q;
    lane_vec_t inv_q;
    lane_vec_t r_dat;

    // Lane k occupies packed bits [k*W : k*W+W-1] of the ascending bus.
    for (genvar k = 0; k < LANES; k++) begin : g_lane_map
        assign eval_vec[k]           = eval_dat[k*W +: W];
        assign inv_r_dat[k*W +: W]   = inv_q[k];
    end

    assign r_dat[0] = mul1_r_dat;
    assign r_dat[1] = mul2_r_dat;
    assign r_dat[2] = mul3_r_dat;
    assign r_dat[3] = mul4_r_dat;
    assign r_dat[4] = mul5_r_dat;
    assign r_dat[5] = mul6_r_dat;
    assign r_dat[6] = mul7_r_dat;
    assign r_dat[7] = mul8_r_dat;
    assign r_dat[8] = mul9_r_dat;

    assign mul1_o_out = o_q[0];
    assign mul2_o_out = o_q[1];
    assign mul3_o_out = o_q[2];
    assign mul4_o_out = o_q[3];
    assign mul5_o_out = o_q[4];
    assign mul6_o_out = o_q[5];
    assign mul7_o_out = o_q[6];
    assign mul8_o_out = o_q[7];
    assign mul9_o_out = o_q[8];

    assign mul1_t_out = t_q[0];
    assign mul2_t_out = t_q[1];
    assign mul3_t_out = t_q[2];
    assign mul4_t_out = t_q[3];
    assign mul5_t_out = t_q[4];
    assign mul6_t_out = t_q[5];
    assign mul7_t_out = t_q[6];
    assign mul8_t_out = t_q[7];
    assign mul9_t_out = t_q[8];

    // Pure product: the shared array computes o*t + add.
    assign mul1_add_out = '0;
    assign mul2_add_out = '0;
    assign mul3_add_out = '0;
    assign mul4_add_out = '0;
    assign mul5_add_out = '0;
    assign mul6_add_out = '0;
    assign mul7_add_out = '0;
    assign mul8_add_out = '0;
    assign mul9_add_out = '0;

    gopf_inv_seq u_seq (
        .clk     (clk),
        .rst_b   (rst_b),
        .load    (accept),
        .advance (advance),
        .op      (op),
        .last_op (last_op)
    );

    always_ff @(posedge clk) begin
        if (rst_b) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                advance = 1'b1;
                state_d = last_op ? DONE : ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            a_q      <= '0;
            r_q      <= '0;
            o_q      <= '0;
            t_q      <= '0;
            inv_q    <= '0;
            inv_done <= 1'b0;
            busy     <= 1'b0;
        end else begin
            inv_done <= 1'b0;
            if (accept) begin
                a_q  <= eval_vec;
                r_q  <= eval_vec;
                busy <= 1'b1;
            end
            if (state_q == ISSUE) begin
                o_q <= r_q;
                t_q <= (op == SQR) ? r_q : a_q;
            end
            if (state_q == CAPTURE) begin
                r_q <= r_dat;
            end
            if (state_q == DONE) begin
                inv_q    <= r_q;
                inv_done <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

`ifdef GOPF_INV_ZERO_FLAG_EN
    logic [LANES-1:0] zero_a_q;

    // Zero lanes already invert to 0; the flag lets the consumer tell them apart.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            zero_a_q  <= '0;
            zero_flag <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < LANES; k++) zero_a_q[k] <= (eval_vec[k] == '0);
            end
            if (state_q == DONE) begin
                for (int k = 0; k < LANES; k++) zero_flag[k] <= zero_a_q[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_gopf_inv_batch.sv
// Directed bench for gopf_inv_batch with a behavioural MUL_ARRAY; define
// GOPF_INV_ZERO_FLAG_EN to also exercise the zero_flag output.
module tb_gopf_inv_batch;

    typedef logic [15:0] lanes_t [9];

    logic         clk = 1'b0;
    logic         rst_b;
    logic         start;
    logic [0:143] eval_dat;
    logic [0:143] inv_r_dat;
    logic         inv_done;
    logic         busy;
`ifdef GOPF_INV_ZERO_FLAG_EN
    logic [0:8]   zero_flag;
`endif
    logic [0:15]  m_o   [1:9];
    logic [0:15]  m_t   [1:9];
    logic [0:15]  m_add [1:9];
    logic [0:15]  m_r   [1:9];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Independent field model: x^16 = x^12 + x^3 + x + 1.
    function automatic logic [15:0] tb_gf_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        logic [15:0] x;
        p = 16'h0000;
        x = a;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) p = p ^ x;
            x = x[15] ? ((x << 1) ^ 16'h100B) : (x << 1);
        end
        return p;
    endfunction

    for (genvar K = 1; K <= 9; K++) begin : g_mul_array
        assign m_r[K] = tb_gf_mul(m_o[K], m_t[K]) ^ m_add[K];
    end

    gopf_inv_batch dut (
        .clk(clk), .rst_b(rst_b), .start(start), .eval_dat(eval_dat),
        .inv_r_dat(inv_r_dat), .inv_done(inv_done), .busy(busy),
`ifdef GOPF_INV_ZERO_FLAG_EN
        .zero_flag(zero_flag),
`endif
        .mul1_o_out(m_o[1]), .mul2_o_out(m_o[2]), .mul3_o_out(m_o[3]),
        .mul4_o_out(m_o[4]), .mul5_o_out(m_o[5]), .mul6_o_out(m_o[6]),
        .mul7_o_out(m_o[7]), .mul8_o_out(m_o[8]), .mul9_o_out(m_o[9]),
        .mul1_t_out(m_t[1]), .mul2_t_out(m_t[2]), .mul3_t_out(m_t[3]),
        .mul4_t_out(m_t[4]), .mul5_t_out(m_t[5]), .mul6_t_out(m_t[6]),
        .mul7_t_out(m_t[7]), .mul8_t_out(m_t[8]), .mul9_t_out(m_t[9]),
        .mul1_add_out(m_add[1]), .mul2_add_out(m_add[2]), .mul3_add_out(m_add[3]),
        .mul4_add_out(m_add[4]), .mul5_add_out(m_add[5]), .mul6_add_out(m_add[6]),
        .mul7_add_out(m_add[7]), .mul8_add_out(m_add[8]), .mul9_add_out(m_add[9]),
        .mul1_r_dat(m_r[1]), .mul2_r_dat(m_r[2]), .mul3_r_dat(m_r[3]),
        .mul4_r_dat(m_r[4]), .mul5_r_dat(m_r[5]), .mul6_r_dat(m_r[6]),
        .mul7_r_dat(m_r[7]), .mul8_r_dat(m_r[8]), .mul9_r_dat(m_r[9])
    );

    function automatic logic [0:143] pack(input lanes_t l);
        logic [0:143] v;
        for (int k = 0; k < 9; k++) v[16*k +: 16] = l[k];
        return v;
    endfunction

    function automatic logic [0:143] fill(input logic [15:0] x);
        logic [0:143] v;
        for (int k = 0; k < 9; k++) v[16*k +: 16] = x;
        return v;
    endfunction

    function automatic logic [15:0] lane(input logic [0:143] v, input int k);
        return v[16*k +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge (edge 0), then scramble eval_dat.
    task automatic start_op(input logic [0:143] d);
        eval_dat = d;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        eval_dat = ~d;
    endtask

    // Edge number (edge 0 = acceptance) on which inv_done is seen, -1 on timeout.
    task automatic wait_done(input int from, output int cyc);
        cyc = -1;
        for (int n = from + 1; n <= from + 150; n++) begin
            tick();
            if (inv_done) begin
                cyc = n;
                break;
            end
        end
    endtask

    lanes_t mix;

    task automatic test_reset();
        rst_b = 1'b1; start = 1'b0; eval_dat = '0;
        repeat (3) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (inv_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", inv_done); end
        n_tests++; if (inv_r_dat !== '0) begin n_fail++; $display("FAIL reset_inv: got %h want 0", inv_r_dat); end
        n_tests++; if (m_o[1] !== 16'h0 || m_t[9] !== 16'h0 || m_add[5] !== 16'h0) begin
            n_fail++; $display("FAIL reset_mul: o1=%h t9=%h add5=%h want 0", m_o[1], m_t[9], m_add[5]);
        end
        rst_b = 1'b0;
        tick();
    endtask

    task automatic test_ones();
        int cyc;
        start_op(fill(16'h0001));
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ones_busy_after_accept: got %b want 1", busy); end
        wait_done(0, cyc);
        n_tests++; if (cyc !== 59) begin n_fail++; $display("FAIL ones_latency: got %0d want 59", cyc); end
        n_tests++; if (inv_r_dat !== fill(16'h0001)) begin n_fail++; $display("FAIL ones_result: got %h want all 0001", inv_r_dat); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ones_busy_at_done: got %b want 0", busy); end
        tick();
        n_tests++; if (inv_done !== 1'b0) begin n_fail++; $display("FAIL ones_done_pulse: got %b want 0", inv_done); end
        n_tests++; if (inv_r_dat !== fill(16'h0001)) begin n_fail++; $display("FAIL ones_hold: got %h want all 0001", inv_r_dat); end
    endtask

    task automatic test_x();
        int cyc;
        start_op(fill(16'h0002));
        wait_done(0, cyc);
        n_tests++; if (cyc !== 59) begin n_fail++; $display("FAIL x_latency: got %0d want 59", cyc); end
        n_tests++; if (inv_r_dat !== fill(16'h8805)) begin n_fail++; $display("FAIL x_result: got %h want all 8805", inv_r_dat); end
        n_tests++; if (tb_gf_mul(16'h0002, lane(inv_r_dat, 4)) !== 16'h0001) begin
            n_fail++; $display("FAIL x_product: got %h want 0001", tb_gf_mul(16'h0002, lane(inv_r_dat, 4)));
        end
`ifdef GOPF_INV_ZERO_FLAG_EN
        n_tests++; if (zero_flag !== 9'b0) begin n_fail++; $display("FAIL x_zero_flag: got %b want 000000000", zero_flag); end
`endif
    endtask

    task automatic test_mixed();
        int cyc;
        start_op(pack(mix));
        wait_done(0, cyc);
        n_tests++; if (cyc !== 59) begin n_fail++; $display("FAIL mixed_latency: got %0d want 59", cyc); end
        n_tests++; if (lane(inv_r_dat, 0) !== 16'h0001 || lane(inv_r_dat, 1) !== 16'h8805) begin
            n_fail++; $display("FAIL mixed_known: got %h %h want 0001 8805", lane(inv_r_dat, 0), lane(inv_r_dat, 1));
        end
        n_tests++; if (lane(inv_r_dat, 2) !== 16'h0000) begin n_fail++; $display("FAIL mixed_zero_lane: got %h want 0000", lane(inv_r_dat, 2)); end
        for (int k = 0; k < 9; k++) begin
            if (mix[k] != 16'h0000) begin
                n_tests++;
                if (tb_gf_mul(mix[k], lane(inv_r_dat, k)) !== 16'h0001) begin
                    n_fail++;
                    $display("FAIL mixed_lane%0d: a=%h inv=%h product=%h want 0001", k, mix[k], lane(inv_r_dat, k), tb_gf_mul(mix[k], lane(inv_r_dat, k)));
                end
            end
        end
`ifdef GOPF_INV_ZERO_FLAG_EN
        n_tests++; if (zero_flag !== 9'b001000000) begin n_fail++; $display("FAIL mixed_zero_flag: got %b want 001000000", zero_flag); end
`endif
    endtask

    task automatic test_ignored_start();
        int first;
        int pulses;
        first = -1; pulses = 0;
        start_op(fill(16'h0002));
        for (int n = 1; n <= 19; n++) tick();
        n_tests++; if (m_add[1] !== 16'h0 || m_add[9] !== 16'h0) begin
            n_fail++; $display("FAIL ign_add_zero: add1=%h add9=%h want 0", m_add[1], m_add[9]);
        end
        eval_dat = fill(16'h0001);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int n = 21; n <= 90; n++) begin
            tick();
            if (inv_done) begin
                pulses++;
                if (first < 0) first = n;
            end
        end
        n_tests++; if (first !== 59) begin n_fail++; $display("FAIL ign_latency: got %0d want 59", first); end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL ign_pulses: got %0d want 1", pulses); end
        n_tests++; if (inv_r_dat !== fill(16'h8805)) begin n_fail++; $display("FAIL ign_result: got %h want all 8805", inv_r_dat); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int cyc;
        pulses = 0;
        start_op(fill(16'h0003));
        for (int n = 1; n <= 29; n++) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        n_tests++; if (busy !== 1'b0 || inv_done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: busy=%b done=%b want 0 0", busy, inv_done);
        end
        n_tests++; if (inv_r_dat !== '0) begin n_fail++; $display("FAIL rst_mid_inv: got %h want 0", inv_r_dat); end
        n_tests++; if (m_o[1] !== 16'h0 || m_t[9] !== 16'h0) begin
            n_fail++; $display("FAIL rst_mid_mul: o1=%h t9=%h want 0", m_o[1], m_t[9]);
        end
        for (int n = 0; n < 70; n++) begin
            tick();
            if (inv_done) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", pulses); end
        start_op(pack(mix));
        wait_done(0, cyc);
        n_tests++; if (cyc !== 59) begin n_fail++; $display("FAIL rst_mid_restart_latency: got %0d want 59", cyc); end
        n_tests++; if (tb_gf_mul(mix[3], lane(inv_r_dat, 3)) !== 16'h0001) begin
            n_fail++; $display("FAIL rst_mid_restart_result: inv=%h product=%h want 0001", lane(inv_r_dat, 3), tb_gf_mul(mix[3], lane(inv_r_dat, 3)));
        end
    endtask

    task automatic test_back_to_back();
        int cyc1;
        int cyc2;
        int held_bad;
        logic [0:143] first_res;
        cyc2 = -1; held_bad = 0;
        start_op(fill(16'h0001));
        wait_done(0, cyc1);
        n_tests++; if (cyc1 !== 59) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 59", cyc1); end
        first_res = inv_r_dat;
        n_tests++; if (first_res !== fill(16'h0001)) begin n_fail++; $display("FAIL b2b_first_result: got %h want all 0001", first_res); end
        eval_dat = fill(16'h0002);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        for (int n = 1; n <= 120; n++) begin
            tick();
            if (inv_done) begin
                cyc2 = n + 1;
                break;
            end
            if (inv_r_dat !== first_res) held_bad++;
        end
        n_tests++; if (cyc2 !== 60) begin n_fail++; $display("FAIL b2b_gap: got %0d want 60", cyc2); end
        n_tests++; if (held_bad !== 0) begin n_fail++; $display("FAIL b2b_hold: got %0d changed cycles want 0", held_bad); end
        n_tests++; if (inv_r_dat !== fill(16'h8805)) begin n_fail++; $display("FAIL b2b_second_result: got %h want all 8805", inv_r_dat); end
    endtask

    initial begin
        mix = '{16'h0001, 16'h0002, 16'h0000, 16'h1234, 16'hFFFF,
                16'h8000, 16'h0003, 16'hABCD, 16'h100B};
        rst_b    = 1'b1;
        start    = 1'b0;
        eval_dat = '0;
        test_reset();
        test_ones();
        test_x();
        test_mixed();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
